// File: rtl/serial_demux_pkg.sv
// Shared types and sizing for the serial packet demultiplexer.
package serial_demux_pkg;

    // Width of the destination-port field; lane count follows from it.
    localparam int PORT_W    = 2;
    // Width of the payload-length field; longest payload is 2**LEN_W-1 bits.
    localparam int LEN_W     = 4;
    localparam int NUM_LANES = 2 ** PORT_W;
    // One counter serves the header phases and the payload, so it must hold
    // both the largest payload length and the longest header field.
    localparam int CNT_W     = LEN_W;

    // Bit counts of the two header phases, pre-sized for the counter load.
    localparam logic [CNT_W-1:0] PORT_BITS = CNT_W'(PORT_W);
    localparam logic [CNT_W-1:0] LEN_BITS  = CNT_W'(LEN_W);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PORT = 2'd1,
        ST_LEN  = 2'd2,
        ST_DATA = 2'd3
    } state_t;

endpackage

// File: rtl/serial_demux_counter.sv
// Loadable down-counter that tracks how many bits remain in the current phase.
module demux_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_is_one
);

    logic [W-1:0] r_count;

    // Load has priority over decrement so a phase change can restart the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec) begin
            r_count <= r_count - 1'b1;
        end
    end

    // A count of one means the bit on the line now is the last of its phase.
    assign o_is_one = (r_count == W'(1));

endmodule

// File: rtl/serial_demux.sv
// Serial packet demultiplexer: start bit, port field, length field, then
// payload bits steered combinationally onto one of the output lanes.
module serial_demux
    import serial_demux_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 SE_in,
    output logic                 Valid,
    output logic [NUM_LANES-1:0] Serial_out,
    output logic [PORT_W-1:0]    Port_number
);

    state_t             r_state;
    state_t             w_state_next;

    // Only the bits preceding the final header bit need storing; the final
    // bit is taken straight from the line when the field is assembled.
    logic [PORT_W-2:0]  r_port_sh;
    logic [LEN_W-2:0]   r_len_sh;
    logic [PORT_W-1:0]  r_port_num;

    logic [PORT_W-1:0]  w_port_asm;
    logic [LEN_W-1:0]   w_len_asm;

    logic               w_cnt_load;
    logic [CNT_W-1:0]   w_cnt_val;
    logic               w_cnt_dec;
    logic               w_cnt_is_one;
    logic               w_port_load;

    // Fields as they stand once the current line bit is shifted in (MSB first).
    assign w_port_asm = {r_port_sh, SE_in};
    assign w_len_asm  = {r_len_sh, SE_in};

    demux_counter #(
        .W (CNT_W)
    ) u_counter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .i_dec      (w_cnt_dec),
        .o_is_one   (w_cnt_is_one)
    );

    // State register; reset abandons any partial packet.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and counter control; each phase loads the counter with its
    // own bit count and leaves when the counter reports its last bit.
    always_comb begin
        w_state_next = r_state;
        w_cnt_load   = 1'b0;
        w_cnt_val    = '0;
        w_cnt_dec    = 1'b0;
        w_port_load  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!SE_in) begin
                    w_state_next = ST_PORT;
                    w_cnt_load   = 1'b1;
                    w_cnt_val    = PORT_BITS;
                end
            end
            ST_PORT: begin
                if (w_cnt_is_one) begin
                    w_state_next = ST_LEN;
                    w_cnt_load   = 1'b1;
                    w_cnt_val    = LEN_BITS;
                    w_port_load  = 1'b1;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            ST_LEN: begin
                if (w_cnt_is_one) begin
                    // A zero-length packet returns straight to idle.
                    if (w_len_asm != '0) begin
                        w_state_next = ST_DATA;
                        w_cnt_load   = 1'b1;
                        w_cnt_val    = w_len_asm;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            ST_DATA: begin
                if (w_cnt_is_one) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Header shift registers; they only advance while their field is on the line.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_port_sh <= '0;
            r_len_sh  <= '0;
        end else begin
            if (r_state == ST_PORT) begin
                r_port_sh <= w_port_asm[PORT_W-2:0];
            end
            if (r_state == ST_LEN) begin
                r_len_sh <= w_len_asm[LEN_W-2:0];
            end
        end
    end

    // Port number holds the last completed port field until the next one lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_port_num <= '0;
        end else if (w_port_load) begin
            r_port_num <= w_port_asm;
        end
    end

    assign Valid       = (r_state == ST_DATA);
    assign Port_number = r_port_num;

    // Zero-latency lane steering: the selected lane mirrors the line during payload.
    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            assign Serial_out[gi] = Valid & (r_port_num == PORT_W'(gi)) & SE_in;
        end
    endgenerate

endmodule

// File: tb/tb_serial_demux.sv
// Self-checking bench for serial_demux: a packet-level parser predicts every
// cycle's outputs from the driven stream, and literal points pin key cycles.
module tb_serial_demux;

    localparam int MAXC = 256;

    logic       clk;
    logic       rst;
    logic       SE_in;
    logic       Valid;
    logic [3:0] Serial_out;
    logic [1:0] Port_number;

    serial_demux dut (
        .clk         (clk),
        .rst         (rst),
        .SE_in       (SE_in),
        .Valid       (Valid),
        .Serial_out  (Serial_out),
        .Port_number (Port_number)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus stream: one entry per clock cycle.
    logic se_a  [MAXC];
    logic rst_a [MAXC];
    int   n;

    // Model predictions per cycle.
    logic       exp_v  [MAXC];
    logic [3:0] exp_so [MAXC];
    logic [1:0] exp_pn [MAXC];

    // Hand-computed literal points.
    int         lit_k  [64];
    logic       lit_v  [64];
    logic [3:0] lit_so [64];
    logic [1:0] lit_pn [64];
    int         nl;

    int  n_chk;
    int  n_pass;
    int  cur_k;
    bit  active;

    task automatic push(input logic b, input logic r);
        se_a[n]  = b;
        rst_a[n] = r;
        n++;
    endtask

    task automatic push_bits(input int val, input int w);
        for (int i = w - 1; i >= 0; i--) push(logic'((val >> i) & 1), 1'b0);
    endtask

    task automatic push_pkt(input int port, input int len, input int data);
        push(1'b0, 1'b0);
        push_bits(port, 2);
        push_bits(len, 4);
        push_bits(data, len);
    endtask

    task automatic add_lit(input int k, input logic v, input logic [3:0] so, input logic [1:0] pn);
        lit_k[nl]  = k;
        lit_v[nl]  = v;
        lit_so[nl] = so;
        lit_pn[nl] = pn;
        nl++;
    endtask

    // Parse the stream as packets and write what each cycle must show.
    task automatic build_model();
        int k;
        int cur_port;
        int prt;
        int len;
        int d;
        int nxt;
        k = 0;
        cur_port = 0;
        while (k < n) begin
            exp_v[k]  = 1'b0;
            exp_so[k] = 4'b0000;
            exp_pn[k] = 2'(cur_port);
            if (rst_a[k]) begin
                cur_port = 0;
                k++;
            end else if (se_a[k]) begin
                k++;
            end else begin
                prt = 0;
                len = 0;
                nxt = n;
                for (int c = k + 1; c < n; c++) begin
                    d = c - k;
                    exp_v[c]  = 1'b0;
                    exp_so[c] = 4'b0000;
                    exp_pn[c] = (d >= 3) ? 2'(prt) : 2'(cur_port);
                    if (d <= 2) prt = prt * 2 + int'(se_a[c]);
                    else if (d <= 6) len = len * 2 + int'(se_a[c]);
                    else begin
                        exp_v[c]  = 1'b1;
                        exp_so[c] = se_a[c] ? 4'(1 << prt) : 4'b0000;
                    end
                    if (rst_a[c]) begin
                        cur_port = 0;
                        nxt = c + 1;
                        break;
                    end
                    if ((d == 6 && len == 0) || (d >= 7 && d == 6 + len)) begin
                        cur_port = prt;
                        nxt = c + 1;
                        break;
                    end
                end
                k = nxt;
            end
        end
    endtask

    // Compare the DUT against the model (and any literal point) every cycle.
    always @(negedge clk) begin
        if (active) begin
            n_chk++;
            if (Valid === exp_v[cur_k] && Serial_out === exp_so[cur_k] && Port_number === exp_pn[cur_k]) begin
                n_pass++;
            end else begin
                $display("FAIL model cyc=%0d got V=%b SO=%b PN=%0d want V=%b SO=%b PN=%0d",
                         cur_k, Valid, Serial_out, Port_number, exp_v[cur_k], exp_so[cur_k], exp_pn[cur_k]);
            end
            for (int l = 0; l < nl; l++) begin
                if (lit_k[l] == cur_k) begin
                    n_chk++;
                    if (Valid === lit_v[l] && Serial_out === lit_so[l] && Port_number === lit_pn[l]) begin
                        n_pass++;
                    end else begin
                        $display("FAIL literal cyc=%0d got V=%b SO=%b PN=%0d want V=%b SO=%b PN=%0d",
                                 cur_k, Valid, Serial_out, Port_number, lit_v[l], lit_so[l], lit_pn[l]);
                    end
                end
            end
        end
    end

    initial begin
        int s1, s2, s2b, s3, s4, s5, s6;
        n = 0; nl = 0; n_chk = 0; n_pass = 0; cur_k = 0; active = 1'b0;
        rst = 1'b1;
        SE_in = 1'b1;

        // Reset held with the line toggling.
        push(1'b0, 1'b1); push(1'b1, 1'b1); push(1'b0, 1'b1);
        add_lit(0, 1'b0, 4'b0000, 2'd0);
        add_lit(2, 1'b0, 4'b0000, 2'd0);
        // Idle line.
        for (int i = 0; i < 20; i++) push(1'b1, 1'b0);
        add_lit(22, 1'b0, 4'b0000, 2'd0);

        // Single packet: port 2, N=3, data 101.
        s1 = n;
        push_pkt(2, 3, 3'b101);
        push(1'b1, 1'b0); push(1'b1, 1'b0);
        add_lit(s1 + 2,  1'b0, 4'b0000, 2'd0);
        add_lit(s1 + 3,  1'b0, 4'b0000, 2'd2);
        add_lit(s1 + 7,  1'b1, 4'b0100, 2'd2);
        add_lit(s1 + 8,  1'b1, 4'b0000, 2'd2);
        add_lit(s1 + 9,  1'b1, 4'b0100, 2'd2);
        add_lit(s1 + 10, 1'b0, 4'b0000, 2'd2);

        // Zero-length packet to port 3, then an immediate packet to port 1.
        s2 = n;
        push_pkt(3, 0, 0);
        s2b = n;
        push_pkt(1, 1, 1);
        push(1'b1, 1'b0); push(1'b1, 1'b0);
        add_lit(s2 + 3,  1'b0, 4'b0000, 2'd3);
        add_lit(s2b,     1'b0, 4'b0000, 2'd3);
        add_lit(s2b + 3, 1'b0, 4'b0000, 2'd1);
        add_lit(s2b + 7, 1'b1, 4'b0010, 2'd1);

        // Back-to-back: port 1 N=2 data 11, then port 0 N=1 data 1.
        s3 = n;
        push_pkt(1, 2, 2'b11);
        s4 = n;
        push_pkt(0, 1, 1);
        push(1'b1, 1'b0); push(1'b1, 1'b0); push(1'b1, 1'b0);
        add_lit(s3 + 7, 1'b1, 4'b0010, 2'd1);
        add_lit(s3 + 8, 1'b1, 4'b0010, 2'd1);
        add_lit(s4,     1'b0, 4'b0000, 2'd1);
        add_lit(s4 + 6, 1'b0, 4'b0000, 2'd0);
        add_lit(s4 + 7, 1'b1, 4'b0001, 2'd0);
        add_lit(s4 + 8, 1'b0, 4'b0000, 2'd0);

        // Mid-packet reset on the 2nd payload bit of an N=5 packet to port 3.
        s5 = n;
        push(1'b0, 1'b0);
        push_bits(3, 2);
        push_bits(5, 4);
        push(1'b1, 1'b0);
        push(1'b1, 1'b1);
        push(1'b1, 1'b0);
        s6 = n;
        push_pkt(2, 2, 2'b01);
        push(1'b1, 1'b0); push(1'b1, 1'b0); push(1'b1, 1'b0);
        add_lit(s5 + 8, 1'b1, 4'b1000, 2'd3);
        add_lit(s5 + 9, 1'b0, 4'b0000, 2'd0);
        add_lit(s6 + 7, 1'b1, 4'b0000, 2'd2);
        add_lit(s6 + 8, 1'b1, 4'b0100, 2'd2);

        build_model();

        // First edge applies reset so cycle 0 starts from a known state.
        @(posedge clk);
        #1;
        for (int k = 0; k < n; k++) begin
            cur_k  = k;
            SE_in  = se_a[k];
            rst    = rst_a[k];
            active = 1'b1;
            @(posedge clk);
            #1;
        end
        active = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/serial_demux.md
Name: serial_demux

Overview:
Serial-packet demultiplexer driven by one continuous serial line (SE_in, idle high). Each packet carries:
- a start bit,
- a 2-bit destination port,
- a 4-bit payload length N,
- N payload bits.

The payload bits are steered, one per clock, to one of four serial output lanes, with Valid marking the payload cycles. It sits between a serial link receiver and four downstream serial consumers.

Parameters:
PORT_W, 2, width of port field; number of lanes = 2**PORT_W
LEN_W, 4, width of payload-length field; max payload 15 bits

Ports:
clk  input  1  rising-edge clock; SE_in sampled on every edge
rst  input  1  synchronous, active-high reset
SE_in  input  1  serial packet stream; idle level 1
Valid  output  1  high during every payload-bit cycle
Serial_out  output  4  lane i carries SE_in when Valid and Port_number==i, else 0
Port_number  output  2  destination port of the current or most recent packet

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, bit counter=0, length register=0, Port_number=0. While in IDLE, Valid=0 and Serial_out=4'b0000. Reset takes priority over everything, including mid-packet, and the partial packet is discarded.
- State machine (Moore, one bit per clock): IDLE, PORT, LEN, DATA.
- IDLE: SE_in=1 -> stay in IDLE. SE_in=0 (start bit) -> PORT, counter cleared.
- PORT: 2 cycles, shifting SE_in MSB first into a port shift register. On the 2nd bit the full 2-bit value loads into Port_number and the state goes to LEN. Port_number keeps its previous value until that load.
- LEN: 4 cycles, shifting SE_in MSB first into the length register. On the 4th bit:
  - if the assembled N != 0 -> DATA, counter loaded with N;
  - if N == 0 -> IDLE with no payload and no Valid pulse.
- DATA: lasts exactly N cycles. The counter decrements each cycle. When it reaches 1, the next state is IDLE.
- Valid is combinational from the state: Valid = (state==DATA).
- Serial_out[i] = Valid & (Port_number==i) & SE_in. This is a zero-latency combinational pass-through, so the payload bit appears in the same cycle it is on SE_in. Non-selected lanes are 0.
- Port_number stays stable after a packet ends until the next packet's port field completes.
- Back-to-back packets: the cycle after the last DATA bit is sampled in IDLE, so a 0 there is a start bit. There is no mandatory gap.
- While in PORT or LEN, SE_in is never interpreted as a start bit. There is no framing-error detection.
- Latency from the start-bit edge:
  - port bits are sampled at edges +1 and +2;
  - length bits at edges +3..+6;
  - payload at edges +7..+6+N.

Decomposition:
- Shared package: state enum (IDLE, PORT, LEN, DATA), PORT_W and LEN_W constants.
- One natural sub-module, demux_counter: a loadable down-counter with load, decrement, and an is_one flag. It is used for the phase bit-counts and the payload length.
- FSM, shift registers and the output mux stay in serial_demux.

Test Plan:
- Reset: hold rst=1 with SE_in toggling for 3 cycles -> Valid=0, Serial_out=0000, Port_number=00 throughout.
- Idle: SE_in held at 1 for 20 cycles -> Valid stays 0, Serial_out stays 0000.
- Single packet: drive 0, then 1 0 (port 2), then 0 0 1 1 (N=3), then 1 0 1. Required response:
  - Port_number=2 from the edge after the 2nd port bit;
  - Valid=1 for exactly 3 cycles;
  - Serial_out=0100, 0000, 0100 across those cycles;
  - other lanes stay 0;
  - then IDLE.
- Zero length: drive 0, 1 1 (port 3), 0 0 0 0 (N=0) -> no Valid pulse, Port_number=3 thereafter, FSM back in IDLE and accepts an immediate start bit.
- Back-to-back: a packet with port 1 and N=2 (data 11), immediately followed by a 0 start bit, port 0, N=1, data 1. Required response:
  - Valid high for 2 cycles with Serial_out=0010 both cycles;
  - Valid then low for 7 header cycles;
  - Valid then high for 1 cycle with Serial_out=0001.
- Mid-packet reset: assert rst during the 2nd DATA bit of an N=5 packet -> Valid=0 on the following cycle, Port_number=0, and the next packet decodes correctly.
